// File: rtl/q1_seq_pkg.sv
// Shared types and constants for the JK state unit step controller.
package q1_seq_pkg;

    localparam int STEP_W_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        STEP,
        CHECK,
        DONE
    } state_e;

    localparam logic [1:0] ST_HIT     = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;
    localparam logic [1:0] ST_ABORT   = 2'b10;

endpackage

// File: rtl/q1_step_controller_if.sv
// Command, response and JK-unit control bundle; master is the command source
// (which also models the JK unit), slave is the controller.
interface q1_step_controller_if
    import q1_seq_pkg::*;
#(
    parameter int STEP_W = STEP_W_DEFAULT
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_target;
    logic              cmd_x;
    logic [1:0]        cmd_ab;
    logic [STEP_W-1:0] cmd_limit;
    logic              abort;
    logic              ctl_e;
    logic              ctl_x;
    logic              ctl_a;
    logic              ctl_b;
    logic [1:0]        q_in;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_status;
    logic [STEP_W-1:0] rsp_steps;
    logic              busy;

    modport master (
        output cmd_valid, cmd_target, cmd_x, cmd_ab, cmd_limit, abort, q_in, rsp_ready,
        input  cmd_ready, ctl_e, ctl_x, ctl_a, ctl_b, rsp_valid, rsp_status, rsp_steps, busy
    );

    modport slave (
        input  cmd_valid, cmd_target, cmd_x, cmd_ab, cmd_limit, abort, q_in, rsp_ready,
        output cmd_ready, ctl_e, ctl_x, ctl_a, ctl_b, rsp_valid, rsp_status, rsp_steps, busy
    );
endinterface

// File: rtl/q1_step_counter.sv
// Saturating enable-pulse counter. With Q1SEQ_TIMEOUT_EN it also holds the
// step limit (captured on clear) and flags count==limit.
module q1_step_counter
    import q1_seq_pkg::*;
#(
    parameter int STEP_W = STEP_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              inc_i,
`ifdef Q1SEQ_TIMEOUT_EN
    input  logic [STEP_W-1:0] limit_i,
    output logic              at_limit_o,
`endif
    output logic [STEP_W-1:0] count_o
);

    logic [STEP_W-1:0] count_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (inc_i && (count_q != '1)) begin
            count_q <= count_q + STEP_W'(1);
        end
    end

    assign count_o = count_q;

`ifdef Q1SEQ_TIMEOUT_EN
    logic [STEP_W-1:0] limit_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            limit_q <= '0;
        end else if (clr_i) begin
            limit_q <= limit_i;
        end
    end

    // The count is zero in ARM, so this also covers the limit==0 case there.
    assign at_limit_o = (count_q == limit_q);
`endif

endmodule

// File: rtl/q1_step_controller.sv
// Steps the JK state unit one enable pulse at a time until its state hits the
// target, the step limit expires (Q1SEQ_TIMEOUT_EN builds only) or abort.
module q1_step_controller
    import q1_seq_pkg::*;
#(
    parameter int STEP_W = STEP_W_DEFAULT
) (
    input logic                 clk,
    input logic                 reset,
    q1_step_controller_if.slave bus
);

    state_e      state_q, state_d;
    logic [1:0]  status_q, status_d;
    logic [1:0]  target_q;
    logic        x_q, a_q, b_q;
    logic        accept;
    logic        hit;
    logic        at_limit;
    logic [STEP_W-1:0] count;

    assign accept = (state_q == IDLE) && bus.cmd_valid;
    assign hit    = (bus.q_in == target_q);

    q1_step_counter #(.STEP_W(STEP_W)) u_counter (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (accept),
        .inc_i      (state_q == STEP),
`ifdef Q1SEQ_TIMEOUT_EN
        .limit_i    (bus.cmd_limit),
        .at_limit_o (at_limit),
`endif
        .count_o    (count)
    );

`ifndef Q1SEQ_TIMEOUT_EN
    assign at_limit = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        unique case (state_q)
            IDLE: if (bus.cmd_valid) state_d = ARM;
            ARM, CHECK: begin
                if (bus.abort) begin
                    state_d  = DONE;
                    status_d = ST_ABORT;
                end else if (hit) begin
                    state_d  = DONE;
                    status_d = ST_HIT;
                end else if (at_limit) begin
                    state_d  = DONE;
                    status_d = ST_TIMEOUT;
                end else begin
                    state_d  = STEP;
                end
            end
            STEP: begin
                if (bus.abort) begin
                    state_d  = DONE;
                    status_d = ST_ABORT;
                end else begin
                    state_d  = CHECK;
                end
            end
            DONE: if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            status_q <= ST_HIT;
            target_q <= '0;
            x_q      <= 1'b0;
            a_q      <= 1'b0;
            b_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            if (accept) begin
                target_q <= bus.cmd_target;
                x_q      <= bus.cmd_x;
                a_q      <= bus.cmd_ab[1];
                b_q      <= bus.cmd_ab[0];
            end
        end
    end

    // Outputs come straight from registers or state decode only.
    assign bus.cmd_ready  = (state_q == IDLE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.ctl_e      = (state_q == STEP);
    assign bus.ctl_x      = x_q;
    assign bus.ctl_a      = a_q;
    assign bus.ctl_b      = b_q;
    assign bus.rsp_valid  = (state_q == DONE);
    assign bus.rsp_status = status_q;
    assign bus.rsp_steps  = count;

endmodule

// File: doc/q1_step_controller.md
# q1_step_controller

Sequencer for the two-bit JK state unit. It accepts a command over a valid/ready handshake and latches the unit's configuration lines (a, b, x). It then pulses the unit's enable one step at a time until the unit's state output equals a requested target, the step limit expires, or the command is aborted. A single response reports the outcome and the number of enable pulses delivered. It sits between the command source (bench or host FSM) and the JK state unit, and is the only driver of that unit's control inputs.

## Interface
- STEP_W, 8: width of step limit and step count.

- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command.
- cmd_target  input  2  state value to reach.
- cmd_x  input  1  value driven on ctl_x for the whole command.
- cmd_ab  input  2  {a,b} driven on ctl_a/ctl_b for the whole command.
- cmd_limit  input  STEP_W  maximum enable pulses (timeout build only).
- abort  input  1  terminate the running command.
- ctl_e, ctl_x, ctl_a, ctl_b  output  1 each  control lines to the JK state unit.
- q_in  input  2  state output of the JK state unit.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  response consumed.
- rsp_status  output  2  00 hit, 01 timeout, 10 aborted, 11 reserved.
- rsp_steps  output  STEP_W  enable pulses delivered.
- busy  output  1  high in any state except IDLE.

## Operation
- States:
  - IDLE: cmd_ready=1.
  - ARM: configuration lines driven, ctl_e=0.
  - STEP: ctl_e=1 for exactly one cycle.
  - CHECK: ctl_e=0; q_in compared.
  - DONE: rsp_valid=1.
- IDLE→ARM on cmd_valid&cmd_ready. On that edge, latch target, x, ab and limit, and clear the step count.
- ARM evaluates in this priority order:
  - abort → DONE/10.
  - q_in==target → DONE/00, steps 0.
  - timeout build with limit==0 → DONE/01.
  - otherwise → STEP.
- STEP always advances the step count by 1 on exit. Exit goes to DONE/10 if abort is high, else to CHECK.
- CHECK evaluates in this priority order:
  - abort → DONE/10.
  - q_in==target → DONE/00.
  - timeout build with count==limit → DONE/01.
  - otherwise → STEP.
- DONE holds rsp_status and rsp_steps stable while rsp_valid&!rsp_ready. On rsp_ready it returns to IDLE.
- abort is ignored in IDLE and DONE. cmd_valid is ignored outside IDLE.
- ctl_x, ctl_a and ctl_b hold the latched command values from ARM through DONE, and keep their last values in IDLE.
- The step count saturates at all-ones and never wraps.

## Timing
- All outputs are registered or decoded from the state register; there are no combinational paths from input to output.
- Reset values: state IDLE, cmd_ready=1, busy=0, ctl_e/x/a/b=0, rsp_valid=0, rsp_status=00, rsp_steps=0.
- Each step takes 2 cycles (STEP + CHECK). q_in is sampled one full cycle after the enable pulse.
- Latency from acceptance edge to rsp_valid: 1 cycle if already at target, otherwise 1+2N cycles for N steps.
- Reset asserted in any state forces the reset values immediately, including mid-pulse. The pending command is discarded and no response is produced.

## Configuration
- Q1SEQ_TIMEOUT_EN defined:
  - cmd_limit is latched and compared as described in Operation.
  - Status 01 is reachable.
- Q1SEQ_TIMEOUT_EN undefined:
  - cmd_limit is ignored and no limit register is built.
  - The controller steps until hit or abort; status 01 is never produced.

## Structure
- Package q1_seq_pkg holds:
  - the state enum (IDLE, ARM, STEP, CHECK, DONE);
  - status constants ST_HIT=2'b00, ST_TIMEOUT=2'b01, ST_ABORT=2'b10;
  - the default STEP_W.
- Sub-module q1_step_counter: saturating STEP_W counter with clear, increment and a terminal-compare-to-limit output. The compare output is present only under Q1SEQ_TIMEOUT_EN.

## Test plan
The bench model of the JK state unit increments q mod 4 on each edge with ctl_e=1. Scenarios 1–5 use a timeout build.
1. q=0, target=3, limit=10:
   - 3 ctl_e pulses, each one cycle wide, separated by one low cycle.
   - rsp_valid 7 cycles after acceptance, status 00, steps 3.
2. q=2, target=2:
   - no ctl_e pulse.
   - rsp_valid 1 cycle after acceptance, status 00, steps 0.
3. Model frozen at q=1, target=3, limit=4:
   - 4 pulses, status 01, steps 4, rsp_valid 9 cycles after acceptance.
   - Non-timeout build: pulses continue until abort.
4. q=0, target=3, abort raised during the second CHECK:
   - ctl_e stays low, status 10, steps 2.
   - Abort raised during a STEP instead: status 10 and that pulse is counted.
5. Back-pressure: rsp_ready=0 for 5 cycles after rsp_valid:
   - rsp fields stable, cmd_ready=0, a new cmd_valid is not accepted.
   - rsp_ready=1 → IDLE and cmd_ready=1 on the next cycle.
6. Reset pulled low mid-STEP:
   - ctl_e, rsp_valid and busy drop to 0 and cmd_ready rises to 1 without waiting for clk.
   - After reset release, the next command behaves as in scenario 1.
